// File: rtl/cp_remove_if.sv
// Sample stream bundle for cp_remove: input sample handshake and output body-sample handshake.
// The slave modport is the cp_remove side; master is the surrounding environment.
interface cp_remove_if #(
  parameter int unsigned num_sz = 16
);
  localparam int unsigned SMP_W = 2 * num_sz;

  logic [SMP_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [SMP_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/cp_remove.sv
// Receive-side cyclic prefix removal: drops Tg guard samples per OFDM symbol, forwards the nfft body.
// Optional symbol counter on sym_count is built only when CP_REMOVE_SYMCNT_EN is defined.
module cp_remove #(
  parameter int unsigned num_sz = 16,
  parameter int unsigned nfft   = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [1:0]    param_tg,
  cp_remove_if.slave    bus,
  output logic [15:0]   sym_count
);
  localparam int unsigned SMP_W = 2 * num_sz;
  localparam int unsigned CNT_W = $clog2(nfft);
  localparam int unsigned TG_W  = $clog2(nfft / 4) + 1;

  typedef enum logic {S_PREFIX, S_BODY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_tg_pend;
  logic [TG_W-1:0]  r_tg_act;
  logic [SMP_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;

  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_tg_end;
  logic w_body_end;

  // Guard code to guard length: nfft/4 down to nfft/32.
  function automatic logic [TG_W-1:0] f_decode(input logic [1:0] code);
    return TG_W'((nfft / 4) >> code);
  endfunction

  // Prefix samples are always dropped, so only the body phase waits on the output stage.
  assign w_in_ready = (r_state == S_PREFIX) | ~r_out_valid | bus.out_ready;
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;
  assign w_tg_end   = (r_cnt == (CNT_W'(r_tg_act) - CNT_W'(1)));
  assign w_body_end = (r_cnt == CNT_W'(nfft - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_PREFIX;
      r_cnt       <= '0;
      r_tg_pend   <= param_tg;
      r_tg_act    <= f_decode(param_tg);
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (load) begin
        r_tg_pend <= param_tg;
      end
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_in_fire) begin
        unique case (r_state)
          S_PREFIX: begin
            if (w_tg_end) begin
              r_cnt   <= '0;
              r_state <= S_BODY;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_BODY: begin
            r_out_data  <= bus.in_data;
            r_out_valid <= 1'b1;
            r_out_last  <= w_body_end;
            if (w_body_end) begin
              r_cnt    <= '0;
              r_state  <= S_PREFIX;
              // A load coinciding with the last body sample already counts for the next symbol.
              r_tg_act <= f_decode(load ? param_tg : r_tg_pend);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;

`ifdef CP_REMOVE_SYMCNT_EN
  logic [15:0] r_sym_count;

  // Completed symbols, counted when the final body sample leaves the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sym_count <= '0;
    end else if (w_out_fire & r_out_last) begin
      r_sym_count <= r_sym_count + 16'd1;
    end
  end

  assign sym_count = r_sym_count;
`else
  assign sym_count = '0;
`endif

endmodule

// File: doc/cp_remove.md
# cp_remove

Receive-side cyclic prefix removal for the WiMAX OFDM chain; it undoes the transmit-side prefix insertion. It sits between the sample front end and the receive FFT. It takes a continuous stream of complex time-domain samples, one sample per accepted transfer, organised as back-to-back OFDM symbols of Tg+Nfft samples. It discards the first Tg samples of every symbol and forwards the Nfft body samples through a one-entry registered output stage, with valid/ready handshakes on both sides.

## Interface
- num_sz, 16, bits per real/imag component; one sample = 2*num_sz bits, imag in the upper half.
- nfft, 256, FFT size; power of two, ≥ 64.
- clk  in  1  single clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- load  in  1  capture param_tg as the pending guard setting.
- param_tg  in  2  guard code: 0→nfft/4, 1→nfft/8, 2→nfft/16, 3→nfft/32.
- in_data  in  2*num_sz  input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  2*num_sz  body sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  out_data is the final (index nfft-1) body sample of a symbol.
- sym_count  out  16  number of completed symbols (see Configuration).

## Operation
- A transfer occurs when in_valid & in_ready (input side) or out_valid & out_ready (output side).
- Registers:
  - tg_pend: 2-bit code.
  - tg_act: guard length, clog2(nfft/4)+1 bits.
  - cnt: clog2(nfft) bits, sample index within the current phase.
  - state: PREFIX or BODY.
  - output register: out_data, out_valid, out_last.
- PREFIX:
  - in_ready=1 unconditionally; accepted samples are dropped.
  - Each accepted sample increments cnt.
  - When the accepted sample has cnt==tg_act-1: cnt←0, state←BODY.
- BODY:
  - in_ready = ~out_valid | out_ready.
  - An accepted sample is loaded into the output register; out_valid←1; out_last←(cnt==nfft-1); cnt increments.
  - When the accepted sample has cnt==nfft-1: cnt←0, state←PREFIX, tg_act←decode(tg_pend).
- out_valid clears on an output transfer that has no simultaneous body load.
- load captures param_tg into tg_pend in any state. A load in the same cycle as the final body sample is applied to the next symbol: the decode uses param_tg directly. The current symbol's guard never changes mid-symbol.
- Output register holds a pending sample across the PREFIX phase. Discarding continues regardless of out_ready.
- Arithmetic: cnt wraps only via the explicit clear. tg_act ≤ nfft/4, so no overflow occurs.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_last=0, out_data=0, sym_count=0.
  - state=PREFIX, cnt=0.
  - tg_pend=param_tg and tg_act=decode(param_tg), sampled during reset.
- Latency: body sample accepted in cycle n appears on out_data with out_valid=1 in cycle n+1.
- Throughput: one sample per cycle with out_ready held high. No bubble at the PREFIX/BODY boundary.
- in_ready is combinational from out_valid, out_ready and state.
- Symbol period: tg_act+nfft accepted input samples yields exactly nfft output transfers.
- Reset mid-operation:
  - Any pending output is discarded; out_valid=0 the following cycle.
  - The next accepted sample is prefix sample 0.

## Configuration
- CP_REMOVE_SYMCNT_EN defined:
  - sym_count increments, wrapping at 2^16, on each output transfer carrying out_last=1.
  - Cleared by reset.
- Undefined: sym_count is constant 0 and its counter logic is not built.

## Test plan
All scenarios use nfft=256.
- Reset with param_tg=3 (Tg=8); stream samples valued 0..263, out_ready=1 → 256 outputs valued 8..263, in order, each one cycle after acceptance. out_last=1 only on 263.
- Same stream with out_ready toggling on a pseudo-random 50% pattern → identical output sequence, no loss or duplication. in_ready=0 in BODY exactly when out_valid=1 & out_ready=0.
- Set up symbol 0 with Tg=8; hold out_ready=0 after body sample 255 and feed the next prefix → in_ready stays 1 for all 8 discarded samples. The sample valued 263 remains on out_data until out_ready rises.
- Pulse load with param_tg=0 at body sample 100 of a Tg=8 symbol → current symbol outputs 256 samples unchanged; next symbol discards 64 samples.
- Pulse load in the same cycle as body sample 255 → the new guard applies to the immediately following symbol.
- Assert reset after 100 body outputs → out_valid=0 the next cycle. The next 8 samples are discarded (param_tg=3), then forwarding resumes.
- With CP_REMOVE_SYMCNT_EN, stream 3 complete Tg=8 symbols → sym_count=3 after the third out_last transfer. Without the macro, sym_count=0 throughout.
